// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for the 16-bit pipeline.
// There is no forwarding, so every in-flight writer is tracked in a
// destination-register scoreboard. A decoded instruction that reads one of
// those registers is held in decode, and a bubble is issued in its place.
// Taken branches and jumps squash fetch/decode for FLUSH_CYCLES cycles.
//
// Ports
//   CLK        clock, all state updates on posedge
//   RST        asynchronous reset, active high
//   WILLWRITE  decoded instruction writes STARTREG
//   STARTREG   destination register of the decoded instruction
//   READREG    decoded instruction reads READREG1
//   READ2      decoded instruction also reads READREG2
//   READREG1   first source register
//   READREG2   second source register
//   TAKEN      execute stage resolved a taken BEQ/JUMP this cycle
//   STAGE1EN   fetch/PC advance enable
//   STAGE2IN   decode captures a new IR/PC
//   STAGE2OUT  decode issues a valid instruction (0 = bubble)
//   STALLED    hazard bubble inserted this cycle
//   FLUSHING   flush bubble inserted this cycle
//   STALLCNT   saturating count of hazard-stall cycles since reset
//
// state | meaning
// RUN   | normal issue, hazard checking active
// FLUSH | squashing fetch/decode after a taken branch/jump
module pipeline_ctrl #(
  parameter int DEPTH        = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int REG0_ZERO    = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       WILLWRITE,
  input  logic [3:0] STARTREG,
  input  logic       READREG,
  input  logic       READ2,
  input  logic [3:0] READREG1,
  input  logic [3:0] READREG2,
  input  logic       TAKEN,
  output logic       STAGE1EN,
  output logic       STAGE2IN,
  output logic       STAGE2OUT,
  output logic       STALLED,
  output logic       FLUSHING,
  output logic [7:0] STALLCNT
);

  localparam logic [0:0] MODE_RUN   = 1'b0;
  localparam logic [0:0] MODE_FLUSH = 1'b1;
  localparam logic [2:0] FC_LOAD    = 3'(FLUSH_CYCLES - 1);

  logic [0:0]       mode;
  logic [2:0]       fc;
  logic [DEPTH-1:0] sb_v;
  logic [3:0]       sb_reg [DEPTH];
  logic [7:0]       stall_cnt;
  logic             hit1;
  logic             hit2;
  logic             haz;

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sb_v[i] && (sb_reg[i] == READREG1)) hit1 = 1'b1;
      if (sb_v[i] && (sb_reg[i] == READREG2)) hit2 = 1'b1;
    end
    if ((REG0_ZERO != 0) && (READREG1 == 4'd0)) hit1 = 1'b0;
    if ((REG0_ZERO != 0) && (READREG2 == 4'd0)) hit2 = 1'b0;
    haz = READREG & (hit1 | (READ2 & hit2));
  end

  // RST is in the output decode so enables drop the moment reset rises,
  // not at the next edge.
  always_comb begin
    STAGE1EN  = 1'b1;
    STAGE2IN  = 1'b1;
    STAGE2OUT = 1'b1;
    STALLED   = 1'b0;
    FLUSHING  = 1'b0;
    if (RST) begin
      STAGE1EN  = 1'b0;
      STAGE2IN  = 1'b0;
      STAGE2OUT = 1'b0;
    end else if (TAKEN || (mode == MODE_FLUSH)) begin
      STAGE2IN  = 1'b0;
      STAGE2OUT = 1'b0;
      FLUSHING  = 1'b1;
    end else if (haz) begin
      STAGE1EN  = 1'b0;
      STAGE2IN  = 1'b0;
      STAGE2OUT = 1'b0;
      STALLED   = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode      <= MODE_RUN;
      fc        <= 3'd0;
      sb_v      <= '0;
      stall_cnt <= 8'd0;
      for (int i = 0; i < DEPTH; i++) sb_reg[i] <= 4'd0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        sb_v[i]   <= sb_v[i-1];
        sb_reg[i] <= sb_reg[i-1];
      end
      // bubbles and squashed slots always push an invalid entry
      sb_v[0]   <= WILLWRITE & STAGE2OUT;
      sb_reg[0] <= STARTREG;

      // TAKEN itself is the first flush bubble, so FLUSH lasts FLUSH_CYCLES-1
      if (TAKEN) begin
        if (FLUSH_CYCLES > 1) begin
          mode <= MODE_FLUSH;
          fc   <= FC_LOAD;
        end else begin
          mode <= MODE_RUN;
          fc   <= 3'd0;
        end
      end else if (mode == MODE_FLUSH) begin
        if (fc <= 3'd1) begin
          mode <= MODE_RUN;
          fc   <= 3'd0;
        end else begin
          fc <= fc - 3'd1;
        end
      end

      if (STALLED && (stall_cnt != 8'hFF)) stall_cnt <= stall_cnt + 8'd1;
    end
  end

  assign STALLCNT = stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       WILLWRITE, READREG, READ2, TAKEN;
  logic [3:0] STARTREG, READREG1, READREG2;
  logic       s1_a, s2i_a, s2o_a, st_a, fl_a;
  logic       s1_b, s2i_b, s2o_b, st_b, fl_b;
  logic [7:0] cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  // {STAGE1EN, STAGE2IN, STAGE2OUT, STALLED, FLUSHING}
  localparam logic [4:0] V_N = 5'b11100;
  localparam logic [4:0] V_S = 5'b00010;
  localparam logic [4:0] V_F = 5'b10001;
  localparam logic [4:0] V_Z = 5'b00000;

  always #5 CLK = ~CLK;

  pipeline_ctrl #(.DEPTH(3), .FLUSH_CYCLES(2), .REG0_ZERO(1)) dut_a (
    .CLK(CLK), .RST(RST), .WILLWRITE(WILLWRITE), .STARTREG(STARTREG),
    .READREG(READREG), .READ2(READ2), .READREG1(READREG1), .READREG2(READREG2),
    .TAKEN(TAKEN), .STAGE1EN(s1_a), .STAGE2IN(s2i_a), .STAGE2OUT(s2o_a),
    .STALLED(st_a), .FLUSHING(fl_a), .STALLCNT(cnt_a));

  pipeline_ctrl #(.DEPTH(3), .FLUSH_CYCLES(2), .REG0_ZERO(0)) dut_b (
    .CLK(CLK), .RST(RST), .WILLWRITE(WILLWRITE), .STARTREG(STARTREG),
    .READREG(READREG), .READ2(READ2), .READREG1(READREG1), .READREG2(READREG2),
    .TAKEN(TAKEN), .STAGE1EN(s1_b), .STAGE2IN(s2i_b), .STAGE2OUT(s2o_b),
    .STALLED(st_b), .FLUSHING(fl_b), .STALLCNT(cnt_b));

  wire [4:0] outs_a = {s1_a, s2i_a, s2o_a, st_a, fl_a};
  wire [4:0] outs_b = {s1_b, s2i_b, s2o_b, st_b, fl_b};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic ww, input logic [3:0] sr, input logic rr,
                        input logic r2, input logic [3:0] rr1, input logic [3:0] rr2,
                        input logic tk);
    WILLWRITE = ww; STARTREG = sr; READREG = rr; READ2 = r2;
    READREG1 = rr1; READREG2 = rr2; TAKEN = tk;
  endtask

  // inputs are applied just after posedge; outputs checked mid-cycle
  task automatic cyc(input string tag, input logic [4:0] ea, input logic [4:0] eb, input bit chk_b);
    #2;
    check_val({tag, "_a"}, 32'(outs_a), 32'(ea));
    if (chk_b) check_val({tag, "_b"}, 32'(outs_b), 32'(eb));
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    set_in(1'b1, 4'd7, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    #1;
    check_val("rst_outs", 32'(outs_a), 32'(V_Z));
    check_val("rst_cnt", 32'(cnt_a), 32'd0);
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;

    // no readers: full issue every cycle
    for (int i = 0; i < 4; i++) cyc("run_free", V_N, V_N, 1'b1);
    check_val("run_cnt", 32'(cnt_a), 32'd0);

    // ADD r1 then reader of r1: three stalls then issue
    set_in(1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    cyc("add_r1", V_N, V_N, 1'b1);
    set_in(1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("raw_stall", V_S, V_S, 1'b1);
    cyc("raw_issue", V_N, V_N, 1'b1);
    check_val("raw_cnt", 32'(cnt_a), 32'd3);

    // r0 writer/reader: suppressed in dut_a, real hazard in dut_b
    set_in(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    cyc("w_r0", V_N, V_N, 1'b1);
    set_in(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("r0_read", V_N, V_S, 1'b1);
    cyc("r0_done", V_N, V_N, 1'b1);
    check_val("r0_cnt_a", 32'(cnt_a), 32'd3);
    check_val("r0_cnt_b", 32'(cnt_b), 32'd6);

    // READREG2 only matters when READ2 is set
    set_in(1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    cyc("w_r5", V_N, V_N, 1'b0);
    set_in(1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 4'd5, 1'b0);
    cyc("sw_nostall", V_N, V_N, 1'b0);
    set_in(1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 4'd5, 1'b0);
    cyc("read2_s1", V_S, V_S, 1'b0);
    cyc("read2_s2", V_S, V_S, 1'b0);
    cyc("read2_go", V_N, V_N, 1'b0);
    check_val("read2_cnt", 32'(cnt_a), 32'd5);

    // TAKEN during a stall: flush wins, squashed slots push invalid entries
    set_in(1'b1, 4'd4, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    cyc("w_r4", V_N, V_N, 1'b0);
    set_in(1'b1, 4'd6, 1'b1, 1'b0, 4'd4, 4'd0, 1'b0);
    cyc("tk_stall", V_S, V_S, 1'b0);
    set_in(1'b1, 4'd6, 1'b1, 1'b0, 4'd4, 4'd0, 1'b1);
    cyc("tk_pulse", V_F, V_F, 1'b0);
    set_in(1'b1, 4'd6, 1'b1, 1'b0, 4'd4, 4'd0, 1'b0);
    cyc("tk_flush2", V_F, V_F, 1'b0);
    set_in(1'b0, 4'd0, 1'b1, 1'b0, 4'd6, 4'd0, 1'b0);
    cyc("tk_resume", V_N, V_N, 1'b0);
    check_val("tk_cnt", 32'(cnt_a), 32'd6);

    // async reset mid-stall
    set_in(1'b1, 4'd9, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    cyc("w_r9", V_N, V_N, 1'b0);
    set_in(1'b0, 4'd0, 1'b1, 1'b0, 4'd9, 4'd0, 1'b0);
    #2;
    check_val("pre_rst_stall", 32'(outs_a), 32'(V_S));
    RST = 1'b1;
    #1;
    check_val("rst_mid_stall", 32'(outs_a), 32'(V_Z));
    @(posedge CLK); #1;
    check_val("rst_stall_cnt", 32'(cnt_a), 32'd0);
    RST = 1'b0;
    cyc("post_rst_issue", V_N, V_N, 1'b1);

    // async reset mid-flush
    set_in(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
    cyc("fl_taken", V_F, V_F, 1'b1);
    set_in(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    #2;
    check_val("pre_rst_flush", 32'(outs_a), 32'(V_F));
    RST = 1'b1;
    #1;
    check_val("rst_mid_flush", 32'(outs_a), 32'(V_Z));
    @(posedge CLK); #1;
    RST = 1'b0;
    cyc("post_rst_flush", V_N, V_N, 1'b1);

    // repeating r1 writer/reader: one issue per four cycles, then saturation
    set_in(1'b1, 4'd1, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0);
    cyc("sat_issue0", V_N, V_N, 1'b0);
    for (int i = 0; i < 3; i++) cyc("sat_stall", V_S, V_S, 1'b0);
    cyc("sat_issue1", V_N, V_N, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
    end
    check_val("sat_cnt6", 32'(cnt_a), 32'd6);
    for (int i = 0; i < 412; i++) begin
      @(posedge CLK); #1;
    end
    check_val("sat_cnt255", 32'(cnt_a), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
